// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the HI/LO multiply/divide unit.
//   mdu_op_t    - 4-bit MDU opcode presented by the execute stage
//   mdu_state_t - sequencer state
//   DIV_ZERO_LO - LO value produced by a divide by zero
//   abs32       - magnitude of an operand, signed or unsigned view
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9,
    OP_NONE  = 4'd15
  } mdu_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ACC  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_t;

  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  // 0x8000_0000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// div_radix2: iterative restoring divider, one quotient bit per cycle.
//   start/signed_op/a/b : load operands (magnitudes taken here)
//   abort               : drop the division in flight
//   quotient/remainder  : sign-corrected results, meaningful while valid=1
//   valid               : high for one cycle after DIV_ITER iterations
module div_radix2
  import mdu_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        abort,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        valid
);
  localparam int CW = $clog2(DIV_ITER + 1);

  logic [31:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d, qneg_q, qneg_d, rneg_q, rneg_d, bz_q, bz_d;
  logic [32:0]   rem_sh;
  logic [33:0]   diff;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    bz_d   = bz_q;
    // quo_q doubles as the dividend shift register
    rem_sh = {rem_q, quo_q[31]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      rem_d  = '0;
      quo_d  = abs32(a, signed_op);
      dvs_d  = abs32(b, signed_op);
      cnt_d  = CW'(DIV_ITER);
      run_d  = 1'b1;
      qneg_d = signed_op & (a[31] ^ b[31]);
      rneg_d = signed_op & a[31];
      bz_d   = (b == 32'd0);
    end else if (run_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
        rem_d = diff[33] ? rem_sh[31:0] : diff[31:0];
        quo_d = {quo_q[30:0], ~diff[33]};
      end else begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      bz_q   <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      bz_q   <= bz_d;
    end
  end

  assign valid     = run_q && (cnt_q == '0);
  // A zero divisor leaves rem=|a| and all-ones quotient; force LO regardless of sign.
  assign quotient  = bz_q ? DIV_ZERO_LO : (qneg_q ? (~quo_q + 32'd1) : quo_q);
  assign remainder = rneg_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: multi-cycle MUL/MADD/MSUB/DIV sequencer and owner of HI/LO.
//   start/op/a/b : execute-stage MDU instruction and operands
//   flush        : kills the op in flight and any HILO write on that edge
//   stall_reqE   : stall request to the hazard unit
//   busy/done    : FSM not idle / HILO written by a multi-cycle op
//   hilo         : current {HI, LO}
// Build option: HILO_MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU; without it
// those opcodes act as NONE and the ACC path is not built.
module hilo_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int DIV_ITER   = 32,
  parameter int MUL_STAGES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  mdu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall_reqE,
  output logic        busy,
  output logic        done,
  output logic [63:0] hilo
);
  mdu_state_t  state_q, state_d;
  mdu_op_t     op_q, op_d;
  logic [63:0] hilo_q, hilo_d;
  logic [1:0]  mul_cnt_q, mul_cnt_d;
  logic [63:0] prod_d;
  logic [63:0] prod_q [MUL_STAGES];
  logic [63:0] ea, eb;
  logic        msgn, mul_ready, div_start, div_valid;
  logic [31:0] div_quo, div_rem;

  function automatic logic op_multi(input mdu_op_t o);
    case (o)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef HILO_MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // 64x64 truncated product of the extended operands is the exact 64-bit result
  // for both signed and unsigned forms.
  always_comb begin
    msgn   = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    ea     = msgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb     = msgn ? {{32{b[31]}}, b} : {32'd0, b};
    prod_d = ea * eb;
  end

  assign mul_ready = (int'(mul_cnt_q) == MUL_STAGES - 1);

  always_comb begin
    state_d    = state_q;
    hilo_d     = hilo_q;
    op_d       = op_q;
    mul_cnt_d  = mul_cnt_q;
    stall_reqE = 1'b0;
    done       = 1'b0;
    div_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        mul_cnt_d  = '0;
        stall_reqE = start && op_multi(op);
        if (start && !flush) begin
          op_d = op;
          case (op)
            OP_MTHI: hilo_d[63:32] = a;
            OP_MTLO: hilo_d[31:0]  = a;
            OP_MULT, OP_MULTU: state_d = S_MUL;
`ifdef HILO_MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: state_d = S_MUL;
`endif
            OP_DIV, OP_DIVU: begin
              state_d   = S_DIV;
              div_start = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        stall_reqE = 1'b1;
        if (mul_ready) begin
          if (op_q == OP_MULT || op_q == OP_MULTU) begin
            hilo_d  = prod_q[MUL_STAGES-1];
            state_d = S_DONE;
          end else begin
            state_d = S_ACC;
          end
        end else begin
          mul_cnt_d = mul_cnt_q + 2'd1;
        end
      end
`ifdef HILO_MDU_MADD_EN
      S_ACC: begin
        stall_reqE = 1'b1;
        hilo_d  = (op_q == OP_MADD || op_q == OP_MADDU) ? hilo_q + prod_q[MUL_STAGES-1]
                                                        : hilo_q - prod_q[MUL_STAGES-1];
        state_d = S_DONE;
      end
`endif
      S_DIV: begin
        stall_reqE = 1'b1;
        if (div_valid) begin
          hilo_d  = {div_rem, div_quo};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // start still shows the retiring instruction here, so it is ignored
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      hilo_d  = hilo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NONE;
      hilo_q    <= '0;
      mul_cnt_q <= '0;
      for (int i = 0; i < MUL_STAGES; i++) prod_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hilo_q    <= hilo_d;
      mul_cnt_q <= mul_cnt_d;
      // stage 0 tracks a/b only while idle, freezing the start-cycle operands
      if (state_q == S_IDLE) prod_q[0] <= prod_d;
      for (int i = 1; i < MUL_STAGES; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  div_radix2 #(.DIV_ITER(DIV_ITER)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (op == OP_DIV),
    .a         (a),
    .b         (b),
    .abort     (flush),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  assign busy = (state_q != S_IDLE);
  assign hilo = hilo_q;

endmodule
